// File: rtl/serial_add_unit_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_add_unit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_unit_full_adder.sv
// One-bit full adder cell used as the serial bit slice.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain sum and majority carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract unit: one result bit per clock, LSB first.
// Subtraction is a + ~b + 1, realised by inverting b at capture and
// seeding the carry flop with 1.
module serial_add_unit
  import serial_add_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             nonzero;
  logic             ovf_q;
  logic             zero_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic             accept;

  FullAdder u_slice (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection; DONE may chain straight into RUN.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, serial bit processing and flag capture on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      nonzero <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      op_a    <= a;
      op_b    <= b ^ {WIDTH{sub}};
      carry   <= sub;
      cnt     <= '0;
      nonzero <= 1'b0;
    end else if (state == RUN) begin
      op_a    <= op_a >> 1;
      op_b    <= op_b >> 1;
      res     <= {fa_sum, res[WIDTH-1:1]};
      carry   <= fa_cout;
      cnt     <= cnt + CW'(1);
      nonzero <= nonzero | fa_sum;
      if (last_bit) begin
        // carry still holds the carry into the MSB at this point
        ovf_q  <= carry ^ fa_cout;
        zero_q <= ~(nonzero | fa_sum);
      end
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign result = res;
  assign cout   = carry;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit (WIDTH=32).
module tb_serial_add_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, cout, ovf, zero;
  logic [W-1:0]  result;

  int total = 0;
  int bad   = 0;

  serial_add_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outputs are a function of edges elapsed since the accepted start:
  // RUN for offsets 0..W-1, DONE at offset W, idle afterwards.
  int           cyc = 0;
  int           acc = 0;
  bit           active = 0;
  bit           started = 0;
  logic [W-1:0] p_res, e_res;
  logic         p_cout, p_ovf, p_zero, e_cout, e_ovf, e_zero;

  task automatic compute(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         output logic [W-1:0] r, output logic c, output logic v, output logic z);
    logic [W:0] full;
    if (!s) begin
      full = {1'b0, x} + {1'b0, y};
      r = full[W-1:0];
      c = full[W];
      v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = x - y;
      c = (x >= y);
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    z = (r == '0);
  endtask

  initial begin
    e_res = '0; e_cout = 0; e_ovf = 0; e_zero = 0;
    p_res = '0; p_cout = 0; p_ovf = 0; p_zero = 0;
  end

  // Model update on every rising edge from the inputs the DUT sees.
  always @(posedge clk) begin
    cyc++;
    started = 1;
    if (rst) begin
      active = 0;
      e_res = '0; e_cout = 0; e_ovf = 0; e_zero = 0;
    end else begin
      if (start && (!active || (cyc - 1 - acc) >= W)) begin
        active = 1;
        acc = cyc;
        compute(a, b, sub, p_res, p_cout, p_ovf, p_zero);
      end
      if (active && (cyc - acc) == W) begin
        e_res = p_res; e_cout = p_cout; e_ovf = p_ovf; e_zero = p_zero;
      end
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      int  d;
      bit  eb, ed;
      d  = cyc - acc;
      eb = active && d >= 0 && d < W;
      ed = active && d == W;
      chk("busy", 64'(busy), 64'(eb));
      chk("done", 64'(done), 64'(ed));
      if (!eb) begin
        chk("result", 64'(result), 64'(e_res));
        chk("cout",   64'(cout),   64'(e_cout));
        chk("ovf",    64'(ovf),    64'(e_ovf));
        chk("zero",   64'(zero),   64'(e_zero));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Single-cycle start, wait for done (bounded), check literal expectations.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [W-1:0] xr, input logic xc, input logic xv, input logic xz,
                        input string tag);
    int lat;
    bit seen;
    start = 1; a = x; b = y; sub = s;
    tick();
    start = 0; a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
    seen = 0; lat = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; lat = i; break; end
    end
    if (!seen) chk({tag, "_timeout"}, 64'(0), 64'(1));
    else begin
      chk({tag, "_latency"}, 64'(lat), 64'(W));
      chk({tag, "_res"},  64'(result), 64'(xr));
      chk({tag, "_cout"}, 64'(cout), 64'(xc));
      chk({tag, "_ovf"},  64'(ovf),  64'(xv));
      chk({tag, "_zero"}, 64'(zero), 64'(xz));
    end
    tick();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    repeat (3) tick();
    // reset state while rst is still high
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    rst = 0;

    run_op(32'd5, 32'd7, 0, 32'd12, 0, 0, 0, "add5_7");
    run_op(32'hFFFF_FFFF, 32'd1, 0, 32'h0, 1, 0, 1, "wrap");
    run_op(32'h7FFF_FFFF, 32'd1, 0, 32'h8000_0000, 0, 1, 0, "posovf");
    run_op(32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 1, 1, 0, "negovf");
    run_op(32'd3, 32'd3, 1, 32'h0, 1, 0, 1, "sub3_3");
    run_op(32'd3, 32'd5, 1, 32'hFFFF_FFFE, 0, 0, 0, "sub3_5");

    // random single operations with random idle gaps
    for (int n = 0; n < 30; n++) begin
      start = 1; a = pick(); b = pick(); sub = $urandom_range(0, 1);
      tick();
      start = 0;
      for (int i = 0; i < W + 1 + int'($urandom_range(0, 3)); i++) begin
        if ($urandom_range(0, 3) == 0) start = 1; else start = 0;
        a = $urandom; b = $urandom;
        // never let a mid-run start stretch into DONE here; the model covers it anyway
        if (i >= W - 1) start = 0;
        tick();
      end
    end

    // start held high: back-to-back operations, operands churn mid-run
    start = 1; a = pick(); b = pick(); sub = $urandom_range(0, 1);
    tick();
    dones = 0;
    for (int i = 0; i < 3 * (W + 1); i++) begin
      @(negedge clk);
      if (done) dones++;
      @(posedge clk); #1;
      a = pick(); b = pick(); sub = $urandom_range(0, 1);
    end
    chk("held_done_count", 64'(dones), 64'(3));
    start = 0;
    repeat (W + 3) tick();

    // reset in the middle of RUN
    start = 1; a = 32'd100; b = 32'd23; sub = 0;
    tick();
    start = 0;
    repeat (9) tick();
    chk("midrun_busy", 64'(busy), 64'(1));
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("postrst_busy", 64'(busy), 64'(0));
    chk("postrst_result", 64'(result), 64'(0));
    repeat (W + 3) tick();
    run_op(32'd100, 32'd23, 1, 32'd77, 1, 0, 0, "after_rst");

    // reset dominates start
    rst = 1; start = 1; a = 32'd1; b = 32'd1; sub = 0;
    tick();
    rst = 0; start = 0;
    @(negedge clk);
    chk("rst_vs_start_busy", 64'(busy), 64'(0));
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_add_unit.md
SERIAL_ADD_UNIT -- requirements
Module: serial_add_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and result width in bits (legal 2..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an operation; sampled only when idle or done.
REQ-005 sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  WIDTH  first operand; sampled with start.
REQ-007 b  input  WIDTH  second operand; sampled with start.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse when result and flags become valid.
REQ-010 result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-011 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-012 ovf  output  1  signed two's-complement overflow.
REQ-013 zero  output  1  result equals 0.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; reset enters IDLE.
REQ-015 IDLE: start=1 -> latch a, b^{WIDTH{sub}}, carry<=sub, bit counter<=0, go RUN; else stay.
REQ-016 RUN: each cycle one bit slice adds operand LSBs plus carry flop; sum bit shifts into result MSB (shift right), operands shift right, carry flop updates, counter increments.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the cycle counter==WIDTH-1, transition to DONE.
REQ-018 Latency: start sampled at edge N -> done high during cycle N+WIDTH+1 (i.e. WIDTH RUN cycles, then DONE).
REQ-019 DONE: done=1 for exactly one cycle; go IDLE unless start=1, in which case new operands are latched and go RUN (back-to-back, no bubble).
REQ-020 busy SHALL equal (state==RUN); start while busy SHALL be ignored with no effect on the running operation.
REQ-021 cout SHALL be the carry flop after the final bit; ovf SHALL be carry-into-MSB XOR carry-out-of-MSB (carry-in captured on final bit).
REQ-022 zero SHALL be 1 iff all WIDTH result bits are 0; computed serially (sticky OR of sum bits) or at DONE, identical externally.
REQ-023 result, cout, ovf, zero SHALL hold stable from DONE until the next accepted start; between accepted start and next done they are don't-care to consumers.
REQ-024 Wrap-around: a+b beyond 2^WIDTH-1 SHALL yield low WIDTH bits with cout=1.

Reset
REQ-025 rst=1 at any edge, including mid-RUN, SHALL force IDLE and clear busy, done, result, cout, ovf, zero, carry, counter to 0; in-flight operation is discarded.
REQ-026 rst SHALL dominate start in the same cycle; first start is accepted on the first edge with rst=0.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-028 The bit slice SHALL be one instance of the team's existing one-bit full adder cell (FullAdder); no other sub-modules.
REQ-029 Counter width SHALL be clog2(WIDTH)+1 bits; no combinational path from inputs to outputs.

Verification
REQ-030 WIDTH=32, a=5, b=7, sub=0, start 1 cycle -> busy 32 cycles, done pulse at cycle 33, result=12, cout=0, ovf=0, zero=0.
REQ-031 a=0xFFFFFFFF, b=1, sub=0 -> result=0, cout=1, ovf=0, zero=1.
REQ-032 a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, ovf=1, cout=0; a=0x80000000, b=1, sub=1 -> result=0x7FFFFFFF, ovf=1.
REQ-033 a=3, b=3, sub=1 -> result=0, zero=1, cout=1; a=3, b=5, sub=1 -> result=0xFFFFFFFE, cout=0.
REQ-034 start held high continuously -> start during RUN ignored, done every 33 cycles, back-to-back from DONE with no IDLE cycle; operands changed mid-RUN do not affect result.
REQ-035 rst asserted at RUN cycle 10 -> next cycle IDLE, all outputs 0, no done pulse; new start afterward completes correctly.
